// File: rtl/iob_nco_meter.sv
// iob_nco_meter: averaging period meter for an external clock-like signal.
// Counts system cycles across 2^k rising edges of sig_i and returns the mean
// period in the NCO fixed-point format (DATA_W integer bits, FRAC_W fraction bits).
//
// Ports:
//   clk_i, rst_n_i      system clock, synchronous active-low reset
//   cke_i               clock enable; low freezes every register
//   enable_i            block enable; low aborts to IDLE
//   start_i, avg_log2_i measurement request and averaging exponent k
//   sig_i               measured asynchronous signal
//   period_o            measured period (int.frac), with period_valid_o/period_ready_i
//   timeout_o           result is a timeout (qualified by period_valid_o)
//   busy_o              measurement in progress or result pending
module iob_nco_meter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned AVG_W  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       cke_i,
    input  logic                       enable_i,
    input  logic                       start_i,
    input  logic [AVG_W-1:0]           avg_log2_i,
    input  logic                       sig_i,
    output logic [DATA_W+FRAC_W-1:0]   period_o,
    output logic                       period_valid_o,
    input  logic                       period_ready_i,
    output logic                       timeout_o,
    output logic                       busy_o
);

    localparam int unsigned PERIOD_W = DATA_W + FRAC_W;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    state_t                state_q, state_d;
    logic                  s1_q, s2_q, s3_q;
    logic [AVG_W-1:0]      k_q, k_d;
    logic [DATA_W-1:0]     gap_q, gap_d;
    logic [FRAC_W-1:0]     edges_q, edges_d;
    logic [PERIOD_W-1:0]   acc_q, acc_d;
    logic [PERIOD_W-1:0]   period_q, period_d;
    logic                  valid_q, valid_d;
    logic                  timeout_q, timeout_d;

    logic                  rise;
    logic [AVG_W-1:0]      k_clamp;
    logic [FRAC_W:0]       edge_lim;
    logic [FRAC_W-1:0]     edges_last;
    logic [DATA_W-1:0]     gap_inc;
    logic                  gap_sat;
    logic [PERIOD_W-1:0]   acc_inc;
    logic [AVG_W-1:0]      shamt;

    // Edge detect on the synchronized signal; the fixed latency cancels between edges.
    assign rise       = s2_q & ~s3_q;
    assign k_clamp    = (avg_log2_i > AVG_W'(FRAC_W)) ? AVG_W'(FRAC_W) : avg_log2_i;
    assign edge_lim   = (FRAC_W+1)'(1) << k_q;
    assign edges_last = FRAC_W'(edge_lim - (FRAC_W+1)'(1));
    assign gap_inc    = gap_q + DATA_W'(1);
    // Gap saturation bounds acc to 2^FRAC_W * (2^DATA_W-1), so PERIOD_W never overflows.
    assign gap_sat    = &gap_inc;
    assign acc_inc    = acc_q + PERIOD_W'(1);
    assign shamt      = AVG_W'(FRAC_W) - k_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        gap_d     = gap_q;
        edges_d   = edges_q;
        acc_d     = acc_q;
        period_d  = period_q;
        valid_d   = valid_q;
        timeout_d = timeout_q;
        if (!enable_i) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = ARM;
                        k_d     = k_clamp;
                        gap_d   = '0;
                        edges_d = '0;
                    end
                end
                ARM: begin
                    gap_d = gap_inc;
                    if (rise) begin
                        acc_d   = '0;
                        gap_d   = '0;
                        edges_d = '0;
                        state_d = MEASURE;
                    end else if (gap_sat) begin
                        period_d  = '0;
                        timeout_d = 1'b1;
                        valid_d   = 1'b1;
                        state_d   = DONE;
                    end
                end
                MEASURE: begin
                    gap_d = gap_inc;
                    acc_d = acc_inc;
                    if (rise) begin
                        gap_d   = '0;
                        edges_d = edges_q + FRAC_W'(1);
                        if (edges_q == edges_last) begin
                            period_d  = acc_inc << shamt;
                            timeout_d = 1'b0;
                            valid_d   = 1'b1;
                            state_d   = DONE;
                        end
                    end else if (gap_sat) begin
                        period_d  = '0;
                        timeout_d = 1'b1;
                        valid_d   = 1'b1;
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    if (valid_q && period_ready_i) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, synchronizer and datapath registers; everything freezes when cke_i is low.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (!rst_n_i) begin
                state_q   <= IDLE;
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                s3_q      <= 1'b0;
                k_q       <= '0;
                gap_q     <= '0;
                edges_q   <= '0;
                acc_q     <= '0;
                period_q  <= '0;
                valid_q   <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                s1_q      <= sig_i;
                s2_q      <= s1_q;
                s3_q      <= s2_q;
                k_q       <= k_d;
                gap_q     <= gap_d;
                edges_q   <= edges_d;
                acc_q     <= acc_d;
                period_q  <= period_d;
                valid_q   <= valid_d;
                timeout_q <= timeout_d;
            end
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = valid_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_iob_nco_meter.sv
// Scoreboard testbench for iob_nco_meter (DATA_W=8, FRAC_W=4, AVG_W=4).
module tb_iob_nco_meter;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned FRAC_W   = 4;
    localparam int unsigned AVG_W    = 4;
    localparam int unsigned PERIOD_W = DATA_W + FRAC_W;

    typedef struct packed {
        logic [PERIOD_W-1:0] period;
        logic                timeout;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cke = 1'b1;
    logic                enable = 1'b1;
    logic                start = 1'b0;
    logic [AVG_W-1:0]    avg = '0;
    logic                sig = 1'b0;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                period_ready = 1'b1;
    logic                timeout;
    logic                busy;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    // Signal generator state
    bit gen_on = 1'b0;
    bit gen_alt = 1'b0;
    int gen_per = 10;
    int gen_cnt = 0;
    bit gen_phase = 1'b0;

    iob_nco_meter #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .AVG_W(AVG_W)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .cke_i          (cke),
        .enable_i       (enable),
        .start_i        (start),
        .avg_log2_i     (avg),
        .sig_i          (sig),
        .period_o       (period),
        .period_valid_o (period_valid),
        .period_ready_i (period_ready),
        .timeout_o      (timeout),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Generator advances only on cycles the DUT will count (cke high at the next edge).
    always @(posedge clk) begin
        int cur;
        #2;
        if (!gen_on) begin
            sig = 1'b0;
            gen_cnt = 0;
        end else if (cke) begin
            cur = (gen_alt && gen_phase) ? gen_per + 1 : gen_per;
            gen_cnt++;
            if (gen_cnt >= cur) begin
                gen_cnt = 0;
                gen_phase = ~gen_phase;
            end
            sig = (gen_cnt < 2);
        end
    end

    // Monitor: every accepted result is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (cke && period_valid && period_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(period), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("period", 32'(period), 32'(e.period));
                chk("timeout", 32'(timeout), 32'(e.timeout));
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_start(input logic [AVG_W-1:0] k);
        tick(1);
        start = 1'b1;
        avg = k;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk({name, "_wait_idle"}, 32'd0, 32'd1);
    endtask

    task automatic run_meas(input int per, input bit alt, input logic [AVG_W-1:0] k,
                            input logic [PERIOD_W-1:0] exp_p, input string name);
        exp_t e;
        gen_per = per;
        gen_alt = alt;
        gen_on = 1'b1;
        e.period = exp_p;
        e.timeout = 1'b0;
        sb.push_back(e);
        issue_start(k);
        wait_idle(name);
    endtask

    initial begin
        exp_t e;
        int   cnt;
        bit   seen;

        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(period_valid), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_timeout", 32'(timeout), 0);
        tick(1);
        rst_n = 1'b1;
        gen_on = 1'b1;
        tick(20);

        // Period 10, k=0: valid for exactly one cycle with ready high
        gen_per = 10;
        e.period = 12'h0A0;
        e.timeout = 1'b0;
        sb.push_back(e);
        issue_start(4'd0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (period_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t1_valid_seen", 32'(seen), 1);
        @(negedge clk);
        chk("t1_valid_one_cycle", 32'(period_valid), 0);
        chk("t1_busy_low", 32'(busy), 0);

        // Alternating 10/11, k=1 -> 10.5
        run_meas(10, 1'b1, 4'd1, 12'h0A8, "t2");
        // Period 7, k=4, and k=9 clamped to 4
        run_meas(7, 1'b0, 4'd4, 12'h070, "t3a");
        run_meas(7, 1'b0, 4'd9, 12'h070, "t3b");

        // Reset mid-MEASURE
        gen_per = 10;
        gen_alt = 1'b0;
        issue_start(4'd2);
        tick(25);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(period_valid), 0);
        chk("midrst_period", 32'(period), 0);
        chk("midrst_timeout", 32'(timeout), 0);
        run_meas(10, 1'b0, 4'd0, 12'h0A0, "fresh");

        // Enable abort mid-MEASURE: no result, period holds its last value
        issue_start(4'd2);
        tick(25);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(period_valid), 0);
        chk("abort_period_held", 32'(period), 32'h0A0);
        tick(60);
        chk("abort_still_idle", 32'(busy), 0);

        // Timeout: sig held low, ready held low
        gen_on = 1'b0;
        period_ready = 1'b0;
        tick(5);
        e.period = '0;
        e.timeout = 1'b1;
        sb.push_back(e);
        issue_start(4'd0);
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (period_valid) begin
                seen = 1'b1;
                break;
            end
            if (busy) cnt++;
        end
        chk("to_valid_seen", 32'(seen), 1);
        chk("to_latency", 32'(cnt), 32'd255);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("to_hold_valid", 32'(period_valid), 1);
            chk("to_hold_period", 32'(period), 0);
            chk("to_hold_timeout", 32'(timeout), 1);
        end
        @(posedge clk);
        #1;
        period_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("to_release_valid", 32'(period_valid), 0);
        chk("to_release_busy", 32'(busy), 0);

        // start pulsed while busy is ignored
        gen_on = 1'b1;
        gen_per = 10;
        tick(20);
        e.period = 12'h0A0;
        e.timeout = 1'b0;
        sb.push_back(e);
        issue_start(4'd0);
        tick(5);
        start = 1'b1;
        avg = 4'd3;
        tick(1);
        start = 1'b0;
        wait_idle("restart");

        // cke freeze mid-measurement
        e.period = 12'h0A0;
        e.timeout = 1'b0;
        sb.push_back(e);
        issue_start(4'd0);
        tick(14);
        cke = 1'b0;
        tick(5);
        cke = 1'b1;
        wait_idle("freeze");

        tick(5);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iob_nco_meter.md
Name: iob_nco_meter

Overview:
- Period meter: the measuring counterpart of the NCO clock generator.
- Samples an external clock-like signal `sig_i` in the system clock domain and counts system cycles across 2^k rising edges.
- Returns the averaged period in the same fixed-point format the NCO period registers take: integer part DATA_W bits, fractional part FRAC_W bits.
- Used to calibrate NCO settings and for closed-loop frequency checks; result is delivered over a valid/ready handshake.

Parameters:
- DATA_W, 32, width of the integer part of the period; also the width of the inter-edge gap counter.
- FRAC_W, 8, width of the fractional part; the maximum usable averaging exponent.
- AVG_W, 4, width of `avg_log2_i`; must satisfy 2^AVG_W > FRAC_W.
- PERIOD_W, DATA_W+FRAC_W, width of the result and of the internal accumulator (derived, not overridden).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, synchronous, active-low.
- cke_i  in  1  clock enable; when low, all registers hold, including the synchronizer.
- enable_i  in  1  block enable; when low, aborts to IDLE.
- start_i  in  1  single-cycle measurement request.
- avg_log2_i  in  AVG_W  averaging exponent k; sampled on an accepted start.
- sig_i  in  1  measured signal, asynchronous.
- period_o  out  PERIOD_W  measured period, fixed point (int.frac).
- period_valid_o  out  1  result valid.
- period_ready_i  in  1  result consumed.
- timeout_o  out  1  result is a timeout; qualified by period_valid_o.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: rst_n_i low at a clk_i edge with cke_i high clears all registers.
  - State returns to IDLE.
  - period_o=0, period_valid_o=0, timeout_o=0, busy_o=0.
  - Any measurement in progress is discarded.
- Input path: sig_i → 2-FF synchronizer → delay flop.
  - rise = s2 & ~s3.
  - Fixed 3-cycle latency from sig_i to rise; it cancels between edges.
- State machine: IDLE, ARM, MEASURE, DONE.
- IDLE:
  - start_i & enable_i → ARM.
  - On that transition: latch k = min(avg_log2_i, FRAC_W); clear gap counter and edge counter.
  - start_i is ignored in every other state.
- ARM:
  - Each cycle, gap += 1.
  - On rise: acc=0, gap=0, edges=0, → MEASURE.
- MEASURE:
  - Each cycle, acc_n = acc+1 and gap += 1.
  - On rise: gap=0, edges += 1.
  - If edges (before increment) == 2^k-1: period_o = acc_n << (FRAC_W-k), timeout_o=0, → DONE.
  - Otherwise acc = acc_n.
- Result meaning:
  - Integer part of period_o = mean period in clk_i cycles.
  - Low k fraction bits come from the averaging; the remaining fraction bits are 0.
  - A rise in the terminating cycle counts that cycle.
- Timeout:
  - In ARM or MEASURE, gap reaching all-ones (2^DATA_W-1) with no rise → DONE with period_o=0, timeout_o=1.
  - This bound guarantees acc ≤ 2^FRAC_W·(2^DATA_W-1), so no overflow in PERIOD_W.
- DONE:
  - period_valid_o=1; period_o and timeout_o held stable.
  - period_valid_o & period_ready_i → IDLE next cycle; period_valid_o drops the following cycle.
  - ready without valid has no effect.
- enable_i low in any state:
  - Next state IDLE; period_valid_o=0, timeout_o=0.
  - period_o holds its last value.
- Simultaneous events:
  - rise and gap-saturation in the same cycle: the rise wins.
  - enable_i low together with handshake: → IDLE, same result.
  - start_i in the handshake cycle: ignored.
- Output registering:
  - All outputs are registered except busy_o, which is decoded from the state register.
  - Result appears 1 cycle after the terminating rise.
- cke_i low: complete freeze. Cycles with cke_i low are not counted.

Test Plan (DATA_W=8, FRAC_W=4, AVG_W=4 unless noted):
- sig_i period 10 cycles, k=0, ready held high → period_o=0x0A0, timeout_o=0, valid for exactly 1 cycle, busy_o then low.
- sig_i alternating 10/11-cycle periods, k=1 → period_o=21<<3=0x0A8 (10.5).
- sig_i period 7, k=4 → period_o=0x070.
  - Repeat with avg_log2_i=9 (clamped to 4) → same 0x070.
- sig_i held 0 after start → timeout_o=1 and period_o=0 exactly 255 cycles after entering ARM.
  - Hold ready low 20 cycles → valid and data stable; on ready → IDLE.
- Reset and enable abort:
  - rst_n_i low mid-MEASURE (period 10, k=2) → next cycle IDLE, all outputs 0.
  - Fresh start → 0x0A0.
  - enable_i low mid-MEASURE → IDLE, no valid.
  - start_i pulsed while busy → no effect on the result.
- Backpressure / freeze: cke_i low for 5 cycles mid-MEASURE, with sig_i stable across the freeze → result excludes frozen cycles, e.g. period 10, k=0 → 0x0A0.
